// File: rtl/block_memory_responder.sv
// Main-memory responder servicing one cache block request at a time: fixed access
// latency, critical-word-first read bursts and sequential write bursts.
module block_memory_responder #(
    parameter int DATA_WIDTH     = 16,
    parameter int TAG_WIDTH      = 16,
    parameter int BLOCK_SIZE     = 4,
    parameter int OFFSET_WIDTH   = 2,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int LATENCY        = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    input  logic [OFFSET_WIDTH-1:0] req_offset,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [OFFSET_WIDTH-1:0] rsp_offset,
    output logic                    rsp_last,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_done,
    output logic [31:0]             read_count,
    output logic [31:0]             write_count
);

    localparam int AW    = MEM_ADDR_WIDTH + OFFSET_WIDTH;
    localparam int WORDS = 1 << AW;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = OFFSET_WIDTH'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, WAIT, READ_BURST, WRITE_BURST} state_t;

    state_t                    state;
    logic [CW-1:0]             lat_cnt;
    logic [MEM_ADDR_WIDTH-1:0] idx_q;
    logic                      write_q;
    logic [OFFSET_WIDTH-1:0]   off_q;
    logic [OFFSET_WIDTH-1:0]   beat;

    // Storage holds data XOR its own word address, so zero-initialised storage
    // reads back as the address-pattern image without any load sequence.
    logic [DATA_WIDTH-1:0]     mem [WORDS];

    logic [MEM_ADDR_WIDTH-1:0] sel_idx;
    logic [OFFSET_WIDTH-1:0]   sel_off;
    logic                      sel_write;
    logic [OFFSET_WIDTH-1:0]   next_beat;
    logic [OFFSET_WIDTH-1:0]   next_off;
    logic [AW-1:0]             rd_addr;
    logic [AW-1:0]             wr_addr;
    logic [DATA_WIDTH-1:0]     rd_word;
    logic                      mem_we;
    logic                      start_burst;

    generate
        if (TAG_WIDTH > MEM_ADDR_WIDTH) begin : g_tag_hi
            logic unused_tag_hi;
            assign unused_tag_hi = ^req_tag[TAG_WIDTH-1:MEM_ADDR_WIDTH];
        end
    endgenerate

    // With zero latency the burst starts on the acceptance edge, so the
    // request fields are used directly instead of their captured copies.
    always_comb begin
        sel_idx   = idx_q;
        sel_off   = off_q;
        sel_write = write_q;
        if (state == IDLE) begin
            sel_idx   = req_tag[MEM_ADDR_WIDTH-1:0];
            sel_off   = req_offset;
            sel_write = req_write;
        end
        next_beat   = beat + OFFSET_WIDTH'(1);
        next_off    = rsp_offset + OFFSET_WIDTH'(1);
        rd_addr     = (state == READ_BURST) ? {idx_q, next_off} : {sel_idx, sel_off};
        rd_word     = mem[rd_addr] ^ DATA_WIDTH'(rd_addr);
        wr_addr     = {idx_q, beat};
        mem_we      = (state == WRITE_BURST) && wr_valid;
        start_burst = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                      ((state == WAIT) && (lat_cnt == '0));
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data ^ DATA_WIDTH'(wr_addr);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            off_q       <= '0;
            beat        <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_offset  <= '0;
            rsp_last    <= 1'b0;
            wr_ready    <= 1'b0;
            wr_done     <= 1'b0;
            read_count  <= '0;
            write_count <= '0;
        end else begin
            wr_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        idx_q     <= req_tag[MEM_ADDR_WIDTH-1:0];
                        write_q   <= req_write;
                        off_q     <= req_offset;
                        req_ready <= 1'b0;
                        if (req_write) write_count <= write_count + 32'd1;
                        else           read_count  <= read_count + 32'd1;
                        if (LATENCY != 0) begin
                            state   <= WAIT;
                            lat_cnt <= CW'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt != '0) lat_cnt <= lat_cnt - CW'(1);
                end
                READ_BURST: begin
                    if (rsp_ready) begin
                        if (rsp_last) begin
                            state     <= IDLE;
                            rsp_valid <= 1'b0;
                            rsp_last  <= 1'b0;
                            req_ready <= 1'b1;
                        end else begin
                            beat       <= next_beat;
                            rsp_offset <= next_off;
                            rsp_data   <= rd_word;
                            rsp_last   <= (next_beat == LAST_BEAT);
                        end
                    end
                end
                WRITE_BURST: begin
                    if (wr_valid) begin
                        beat <= next_beat;
                        if (beat == LAST_BEAT) begin
                            state     <= IDLE;
                            wr_ready  <= 1'b0;
                            wr_done   <= 1'b1;
                            req_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Burst launch overrides the per-state updates above.
            if (start_burst) begin
                beat <= '0;
                if (sel_write) begin
                    state    <= WRITE_BURST;
                    wr_ready <= 1'b1;
                end else begin
                    state      <= READ_BURST;
                    rsp_valid  <= 1'b1;
                    rsp_data   <= rd_word;
                    rsp_offset <= sel_off;
                    rsp_last   <= (LAST_BEAT == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_block_memory_responder.sv
// Self-checking bench for block_memory_responder: directed scenarios plus random
// reads/writes compared against a flat word-array model of the backing store.
module tb_block_memory_responder;

    localparam int DW  = 16;
    localparam int TW  = 16;
    localparam int BS  = 4;
    localparam int OW  = 2;
    localparam int MW  = 8;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [TW-1:0] req_tag = '0;
    logic [OW-1:0] req_offset = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [OW-1:0] rsp_offset;
    logic          rsp_last;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          wr_done;
    logic [31:0]   read_count;
    logic [31:0]   write_count;

    always #5 clk = ~clk;

    block_memory_responder #(
        .DATA_WIDTH(DW), .TAG_WIDTH(TW), .BLOCK_SIZE(BS), .OFFSET_WIDTH(OW),
        .MEM_ADDR_WIDTH(MW), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_tag(req_tag), .req_offset(req_offset),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_offset(rsp_offset), .rsp_last(rsp_last),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_done(wr_done),
        .read_count(read_count), .write_count(write_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: backing store as a flat array of words, plus request counts.
    logic [DW-1:0] mdl [BS << MW];
    int exp_rd = 0;
    int exp_wr = 0;

    // Results gathered by the transaction drivers.
    logic [DW-1:0] got_data [BS];
    logic [OW-1:0] got_off  [BS];
    logic          got_last [BS];
    logic [DW-1:0] held_data [16];
    logic [OW-1:0] held_off  [16];
    logic [DW-1:0] wdat [BS];
    int   got_n, held_n, lat_seen, acc_wait, done_cnt;
    logic timed_out, busy_ready_seen, wr_done_at_acc;

    function automatic logic [DW-1:0] model_word(input logic [TW-1:0] tag, input int off);
        return mdl[(int'(tag) % (1 << MW)) * BS + (off % BS)];
    endfunction

    task automatic accept_req(input logic wr, input logic [TW-1:0] tag, input logic [OW-1:0] off,
                              input bit keep);
        int n = 0;
        bit acc = 0;
        req_valid = 1'b1; req_write = wr; req_tag = tag; req_offset = off;
        while (!acc && n < 60) begin
            acc = req_ready;
            @(posedge clk); #1;
            if (!acc) n++;
        end
        acc_wait = n;
        if (!keep) req_valid = 1'b0;
        if (!acc) timed_out = 1'b1;
        else if (wr) exp_wr++;
        else exp_rd++;
        wr_done_at_acc = wr_done;
    endtask

    task automatic read_txn(input logic [TW-1:0] tag, input int off, input int hold_beat,
                            input int hold_cycles, input bit keep);
        int k = 0, cyc = 0, hl = hold_cycles;
        timed_out = 1'b0; got_n = 0; held_n = 0; busy_ready_seen = 1'b0;
        accept_req(1'b0, tag, OW'(off), keep);
        while (!rsp_valid && k < 60) begin
            if (req_ready) busy_ready_seen = 1'b1;
            @(posedge clk); #1; k++;
        end
        lat_seen = k;
        while (got_n < BS && cyc < 100) begin
            if (got_n == hold_beat && hl > 0) begin rsp_ready = 1'b0; hl--; end
            else rsp_ready = 1'b1;
            if (req_ready) busy_ready_seen = 1'b1;
            if (rsp_valid && !rsp_ready) begin
                if (held_n < 16) begin
                    held_data[held_n] = rsp_data; held_off[held_n] = rsp_offset; held_n++;
                end
            end else if (rsp_valid) begin
                got_data[got_n] = rsp_data; got_off[got_n] = rsp_offset;
                got_last[got_n] = rsp_last; got_n++;
            end
            @(posedge clk); #1; cyc++;
        end
        if (got_n < BS) timed_out = 1'b1;
        rsp_ready = 1'b0;
    endtask

    task automatic write_txn(input logic [TW-1:0] tag, input int gap_beat, input int gap_cycles,
                             input int limit);
        int k = 0, cyc = 0, gl = gap_cycles, nb = 0;
        bit xfer;
        timed_out = 1'b0; done_cnt = 0;
        accept_req(1'b1, tag, '0, 1'b0);
        while (!wr_ready && k < 60) begin @(posedge clk); #1; k++; end
        lat_seen = k;
        while (nb < limit && cyc < 100) begin
            if (nb == gap_beat && gl > 0) begin wr_valid = 1'b0; gl--; end
            else begin wr_valid = 1'b1; wr_data = wdat[nb]; end
            xfer = wr_valid && wr_ready;
            if (wr_done) done_cnt++;
            @(posedge clk); #1; cyc++;
            if (xfer) begin
                mdl[(int'(tag) % (1 << MW)) * BS + nb] = wdat[nb];
                nb++;
            end
        end
        if (wr_done) done_cnt++;
        wr_valid = 1'b0;
        if (nb < limit) timed_out = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_last !== 1'b0) begin errors++; $display("FAIL reset_rsp_flags: got valid=%b last=%b want 0 0", rsp_valid, rsp_last); end
        checks++; if (wr_ready !== 1'b0 || wr_done !== 1'b0) begin errors++; $display("FAIL reset_wr_flags: got ready=%b done=%b want 0 0", wr_ready, wr_done); end
        checks++; if (rsp_data !== '0 || rsp_offset !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h/%0d want 0/0", rsp_data, rsp_offset); end
        checks++; if (read_count !== 32'd0 || write_count !== 32'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", read_count, write_count); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_basic;
        logic [DW-1:0] ed [BS] = '{16'h0041, 16'h0042, 16'h0043, 16'h0040};
        logic [OW-1:0] eo [BS] = '{2'd1, 2'd2, 2'd3, 2'd0};
        read_txn(16'h0010, 1, -1, 0, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL read_basic_timeout: got timeout want completion"); end
        checks++; if (lat_seen != LAT) begin errors++; $display("FAIL read_basic_latency: got %0d want %0d", lat_seen, LAT); end
        for (int k = 0; k < BS; k++) begin
            checks++;
            if (got_off[k] !== eo[k] || got_data[k] !== ed[k] || got_last[k] !== (k == BS - 1)) begin
                errors++;
                $display("FAIL read_basic_beat%0d: got off=%0d data=%h last=%b want off=%0d data=%h last=%b",
                         k, got_off[k], got_data[k], got_last[k], eo[k], ed[k], k == BS - 1);
            end
        end
        checks++; if (read_count !== 32'd1) begin errors++; $display("FAIL read_basic_count: got %0d want 1", read_count); end
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL read_basic_idle: got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_alias;
        read_txn(16'h0110, 0, -1, 0, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL alias_timeout: got timeout want completion"); end
        for (int k = 0; k < BS; k++) begin
            checks++;
            if (got_data[k] !== model_word(16'h0010, k) || got_off[k] !== OW'(k)) begin
                errors++;
                $display("FAIL alias_beat%0d: got %h@%0d want %h@%0d", k, got_data[k], got_off[k], model_word(16'h0010, k), k);
            end
        end
    endtask

    task automatic test_stall;
        read_txn(16'h0005, 2, 1, 2, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout: got timeout want completion"); end
        checks++; if (held_n != 2) begin errors++; $display("FAIL stall_hold_cycles: got %0d want 2", held_n); end
        for (int h = 0; h < held_n && h < 16; h++) begin
            checks++;
            if (held_off[h] !== 2'd3 || held_data[h] !== 16'h0017) begin
                errors++;
                $display("FAIL stall_held%0d: got %h@%0d want 0017@3", h, held_data[h], held_off[h]);
            end
        end
        for (int k = 0; k < BS; k++) begin
            checks++;
            if (got_data[k] !== model_word(16'h0005, 2 + k) || got_off[k] !== OW'(2 + k)) begin
                errors++;
                $display("FAIL stall_beat%0d: got %h@%0d want %h@%0d", k, got_data[k], got_off[k], model_word(16'h0005, 2 + k), (2 + k) % BS);
            end
        end
        checks++; if (read_count !== 32'(exp_rd)) begin errors++; $display("FAIL stall_count: got %0d want %0d", read_count, exp_rd); end
    endtask

    task automatic test_write_then_read;
        logic [DW-1:0] ed [BS] = '{16'hCCCF, 16'hCCCC, 16'hCCCD, 16'hCCCE};
        wdat = '{16'hCCCC, 16'hCCCD, 16'hCCCE, 16'hCCCF};
        write_txn(16'h0030, 2, 1, BS);
        checks++; if (timed_out) begin errors++; $display("FAIL write_timeout: got timeout want completion"); end
        checks++; if (lat_seen != LAT) begin errors++; $display("FAIL write_latency: got %0d want %0d", lat_seen, LAT); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL write_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (wr_done !== 1'b1 || req_ready !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL write_done_state: got done=%b req_ready=%b wr_ready=%b want 1 1 0", wr_done, req_ready, wr_ready); end
        checks++; if (write_count !== 32'd1) begin errors++; $display("FAIL write_count: got %0d want 1", write_count); end
        read_txn(16'h0030, 3, -1, 0, 1'b0);
        checks++; if (acc_wait != 0 || wr_done_at_acc !== 1'b0) begin errors++; $display("FAIL raw_accept_on_done: got wait=%0d done=%b want 0 0", acc_wait, wr_done_at_acc); end
        for (int k = 0; k < BS; k++) begin
            checks++;
            if (got_data[k] !== ed[k]) begin errors++; $display("FAIL raw_beat%0d: got %h want %h", k, got_data[k], ed[k]); end
        end
    endtask

    task automatic test_back_to_back;
        int base = exp_rd;
        read_txn(16'h0022, 0, -1, 0, 1'b1);
        checks++; if (busy_ready_seen) begin errors++; $display("FAIL b2b_ready_while_busy: got 1 want 0"); end
        checks++; if (read_count !== 32'(base + 1)) begin errors++; $display("FAIL b2b_first_count: got %0d want %0d", read_count, base + 1); end
        read_txn(16'h0022, 0, -1, 0, 1'b0);
        checks++; if (acc_wait != 0) begin errors++; $display("FAIL b2b_accept_wait: got %0d want 0", acc_wait); end
        checks++; if (read_count !== 32'(base + 2)) begin errors++; $display("FAIL b2b_second_count: got %0d want %0d", read_count, base + 2); end
        checks++; if (got_data[0] !== model_word(16'h0022, 0)) begin errors++; $display("FAIL b2b_data: got %h want %h", got_data[0], model_word(16'h0022, 0)); end
    endtask

    task automatic test_reset_mid_write;
        logic [DW-1:0] ed [BS] = '{16'hAAAA, 16'hBBBB, 16'h0102, 16'h0103};
        wdat = '{16'hAAAA, 16'hBBBB, 16'h1111, 16'h2222};
        write_txn(16'h0040, -1, 0, 2);
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL midwr_in_burst: got wr_ready=%b want 1", wr_ready); end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || wr_ready !== 1'b0 || wr_done !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL midwr_flags: got req_ready=%b wr_ready=%b done=%b valid=%b want 1 0 0 0", req_ready, wr_ready, wr_done, rsp_valid); end
        checks++; if (read_count !== 32'd0 || write_count !== 32'd0) begin errors++; $display("FAIL midwr_counts: got %0d/%0d want 0/0", read_count, write_count); end
        reset = 1'b1;
        exp_rd = 0; exp_wr = 0;
        @(posedge clk); #1;
        read_txn(16'h0040, 0, -1, 0, 1'b0);
        for (int k = 0; k < BS; k++) begin
            checks++;
            if (got_data[k] !== ed[k]) begin errors++; $display("FAIL midwr_read_beat%0d: got %h want %h", k, got_data[k], ed[k]); end
        end
        checks++; if (read_count !== 32'd1 || write_count !== 32'd0) begin errors++; $display("FAIL midwr_after_counts: got %0d/%0d want 1/0", read_count, write_count); end
    endtask

    task automatic test_random;
        logic [TW-1:0] tag;
        int off;
        for (int it = 0; it < 30; it++) begin
            tag = TW'($urandom) & 16'hFF03;
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < BS; b++) wdat[b] = DW'($urandom);
                write_txn(tag, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), BS);
                checks++; if (timed_out || lat_seen != LAT) begin errors++; $display("FAIL rnd%0d_write_timing: got timeout=%b lat=%0d want 0 %0d", it, timed_out, lat_seen, LAT); end
                checks++; if (done_cnt != 1 || wr_done !== 1'b1) begin errors++; $display("FAIL rnd%0d_write_done: got pulses=%0d done=%b want 1 1", it, done_cnt, wr_done); end
                checks++; if (write_count !== 32'(exp_wr)) begin errors++; $display("FAIL rnd%0d_write_count: got %0d want %0d", it, write_count, exp_wr); end
            end else begin
                off = int'($urandom_range(0, BS - 1));
                read_txn(tag, off, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
                checks++; if (timed_out || lat_seen != LAT) begin errors++; $display("FAIL rnd%0d_read_timing: got timeout=%b lat=%0d want 0 %0d", it, timed_out, lat_seen, LAT); end
                for (int k = 0; k < BS; k++) begin
                    checks++;
                    if (got_data[k] !== model_word(tag, off + k) || got_off[k] !== OW'(off + k) ||
                        got_last[k] !== (k == BS - 1)) begin
                        errors++;
                        $display("FAIL rnd%0d_read_beat%0d: got %h@%0d last=%b want %h@%0d last=%b", it, k,
                                 got_data[k], got_off[k], got_last[k], model_word(tag, off + k), (off + k) % BS, k == BS - 1);
                    end
                end
                checks++; if (read_count !== 32'(exp_rd)) begin errors++; $display("FAIL rnd%0d_read_count: got %0d want %0d", it, read_count, exp_rd); end
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << MW); i++)
            for (int j = 0; j < BS; j++)
                mdl[i * BS + j] = DW'(i * BS + j);
        test_reset();
        test_read_basic();
        test_alias();
        test_stall();
        test_write_then_read();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
